// File: rtl/seg_scan_if.sv
// Display scan bus: shadow-set update inputs from the host, driver word/strobe outputs.
// The master drives the inputs and the slave (the scan controller) drives the driver side.
interface seg_scan_if;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        upd;
    logic [15:0] data_out;
    logic        s_en;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output digits, dp_mask, blank_mask, blink_mask, upd,
        input  data_out, s_en, digit_idx, frame_tick
    );

    modport slave (
        input  digits, dp_mask, blank_mask, blink_mask, upd,
        output data_out, s_en, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler for a 74HC595 driver: builds one driver word per frame
// and strobes s_en at a fixed slot so a reload never lands mid-shift.
module seg_scan_ctrl #(
    parameter int FRAME_CLKS   = 66,
    parameter int LOAD_POS     = 64,
    parameter int DWELL_FRAMES = 16,
    parameter int BLINK_SCANS  = 32
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int FC_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int SC_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_CLKS - 1);
    localparam logic [FC_W-1:0] LOAD_PRE   = FC_W'(LOAD_POS - 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
    localparam logic [SC_W-1:0] SCAN_LAST  = SC_W'(BLINK_SCANS - 1);

    logic [FC_W-1:0] r_frame_cnt;
    logic [DW_W-1:0] r_dwell_cnt;
    logic [SC_W-1:0] r_scan_cnt;
    logic            r_blink_phase;
    logic [1:0]      r_digit_idx;
    logic            r_pending;
    logic [15:0]     r_data_out;
    logic            r_s_en;

    logic [15:0] r_sh_digits, r_act_digits;
    logic [3:0]  r_sh_dp, r_act_dp;
    logic [3:0]  r_sh_blank, r_act_blank;
    logic [3:0]  r_sh_blink, r_act_blink;

    logic        w_frame_tick;
    logic        w_dwell_end;
    logic        w_wrap;
    logic        w_load;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg;
    logic [3:0]  w_sel;
    logic        w_off;
    logic [15:0] w_word;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_frame_tick = (r_frame_cnt == FRAME_LAST);
        w_dwell_end  = w_frame_tick && (r_dwell_cnt == DWELL_LAST);
        w_wrap       = w_dwell_end && (r_digit_idx == 2'd3);
        w_load       = (r_frame_cnt == LOAD_PRE);
        w_nibble     = r_act_digits[{r_digit_idx, 2'b00} +: 4];
        w_seg        = hex7(w_nibble);
        w_sel        = 4'b0001 << r_digit_idx;
        // Blink phase only moves at scan wrap, so every digit of a scan sees the same phase.
        w_off        = r_act_blank[r_digit_idx] | (r_blink_phase & r_act_blink[r_digit_idx]);
        w_word       = w_off ? 16'hFF00 : {~r_act_dp[r_digit_idx], ~w_seg, 4'b0000, w_sel};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt   <= '0;
            r_dwell_cnt   <= '0;
            r_scan_cnt    <= '0;
            r_blink_phase <= 1'b0;
            r_digit_idx   <= 2'd0;
            r_data_out    <= 16'hFF00;
            r_s_en        <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_tick ? '0 : r_frame_cnt + 1'b1;
            r_s_en      <= w_load;
            if (w_load)
                r_data_out <= w_word;
            if (w_frame_tick)
                r_dwell_cnt <= w_dwell_end ? '0 : r_dwell_cnt + 1'b1;
            if (w_dwell_end)
                r_digit_idx <= r_digit_idx + 2'd1;
            if (w_wrap) begin
                if (r_scan_cnt == SCAN_LAST) begin
                    r_scan_cnt    <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                end
            end
        end
    end

    // A wrap promotes what was already pending; an upd on that same edge waits for the next wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending    <= 1'b0;
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= 4'hF;
            r_sh_blink   <= '0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= 4'hF;
            r_act_blink  <= '0;
        end else begin
            if (w_wrap && r_pending) begin
                r_act_digits <= r_sh_digits;
                r_act_dp     <= r_sh_dp;
                r_act_blank  <= r_sh_blank;
                r_act_blink  <= r_sh_blink;
                r_pending    <= 1'b0;
            end
            if (bus.upd) begin
                r_sh_digits <= bus.digits;
                r_sh_dp     <= bus.dp_mask;
                r_sh_blank  <= bus.blank_mask;
                r_sh_blink  <= bus.blink_mask;
                r_pending   <= 1'b1;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.s_en       = r_s_en;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.frame_tick = w_frame_tick;
endmodule
